// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - register-read stage: drives read addresses, patches stale operands, two-deep valid/ready buffering
//
// Ports:
//   clk, rst_n                pipeline clock, asynchronous active-low reset
//   flush                     synchronous kill of both held instructions
//   in_valid/in_ready         decode handshake; in_pc/op/ra/rb/rd/imm are the offered fields
//   raddr0/raddr1             register file read addresses
//   rdata0/rdata1             register file read data, one cycle after the address
//   wen*/waddr*/wdata*        writeback ports 0 and 1 (port 1 wins on a common address)
//   out_valid/out_ready       execute handshake
//   out_pc/op/rd/imm          carried fields; out_a/out_b final operands
module operand_fetch #(
    parameter int OPW = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [31:0]    in_pc,
    input  logic [OPW-1:0] in_op,
    input  logic [4:0]     in_ra,
    input  logic [4:0]     in_rb,
    input  logic [4:0]     in_rd,
    input  logic [31:0]    in_imm,
    output logic [4:0]     raddr0,
    output logic [4:0]     raddr1,
    input  logic [31:0]    rdata0,
    input  logic [31:0]    rdata1,
    input  logic           wen0,
    input  logic [4:0]     waddr0,
    input  logic [31:0]    wdata0,
    input  logic           wen1,
    input  logic [4:0]     waddr1,
    input  logic [31:0]    wdata1,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [31:0]    out_pc,
    output logic [OPW-1:0] out_op,
    output logic [4:0]     out_rd,
    output logic [31:0]    out_imm,
    output logic [31:0]    out_a,
    output logic [31:0]    out_b
);

    logic           s1_valid;
    logic [31:0]    s1_pc;
    logic [OPW-1:0] s1_op;
    logic [4:0]     s1_ra;
    logic [4:0]     s1_rb;
    logic [4:0]     s1_rd;
    logic [31:0]    s1_imm;

    logic [4:0]     out_ra;
    logic [4:0]     out_rb;

    logic           snap_wen0;
    logic [4:0]     snap_waddr0;
    logic [31:0]    snap_wdata0;
    logic           snap_wen1;
    logic [4:0]     snap_waddr1;
    logic [31:0]    snap_wdata1;

    logic           out_free;
    logic           s1_move;
    logic [31:0]    s1_a;
    logic [31:0]    s1_b;
    logic [31:0]    snoop_a;
    logic [31:0]    snoop_b;

    // r0 reads as zero; otherwise the newest matching write wins, port 1 ahead of port 0.
    function automatic logic [31:0] patch(
        input logic [31:0] base,
        input logic [4:0]  r,
        input logic        w1,
        input logic [4:0]  a1,
        input logic [31:0] d1,
        input logic        w0,
        input logic [4:0]  a0,
        input logic [31:0] d0
    );
        if (r == 5'd0)
            return 32'd0;
        else if (w1 && (a1 == r))
            return d1;
        else if (w0 && (a0 == r))
            return d0;
        else
            return base;
    endfunction

    assign out_free = !out_valid || out_ready;
    assign s1_move  = s1_valid && out_free;
    assign in_ready = !s1_valid || s1_move;

    // A stalled S1 keeps re-reading its own registers so rdata stays current.
    assign raddr0 = (s1_valid && !s1_move) ? s1_ra : in_ra;
    assign raddr1 = (s1_valid && !s1_move) ? s1_rb : in_rb;

    // rdata misses the write committed at the edge that captured it; the snapshot fills that gap.
    assign s1_a = patch(rdata0, s1_ra, snap_wen1, snap_waddr1, snap_wdata1,
                        snap_wen0, snap_waddr0, snap_wdata0);
    assign s1_b = patch(rdata1, s1_rb, snap_wen1, snap_waddr1, snap_wdata1,
                        snap_wen0, snap_waddr0, snap_wdata0);

    // Held OUT operands track writes committing while execute is stalled.
    assign snoop_a = patch(out_a, out_ra, wen1, waddr1, wdata1, wen0, waddr0, wdata0);
    assign snoop_b = patch(out_b, out_rb, wen1, waddr1, wdata1, wen0, waddr0, wdata0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_pc       <= '0;
            s1_op       <= '0;
            s1_ra       <= '0;
            s1_rb       <= '0;
            s1_rd       <= '0;
            s1_imm      <= '0;
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_op      <= '0;
            out_rd      <= '0;
            out_imm     <= '0;
            out_a       <= '0;
            out_b       <= '0;
            out_ra      <= '0;
            out_rb      <= '0;
            snap_wen0   <= 1'b0;
            snap_waddr0 <= '0;
            snap_wdata0 <= '0;
            snap_wen1   <= 1'b0;
            snap_waddr1 <= '0;
            snap_wdata1 <= '0;
        end else begin
            snap_wen0   <= wen0;
            snap_waddr0 <= waddr0;
            snap_wdata0 <= wdata0;
            snap_wen1   <= wen1;
            snap_waddr1 <= waddr1;
            snap_wdata1 <= wdata1;

            if (flush) begin
                s1_valid  <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                if (s1_move) begin
                    out_valid <= 1'b1;
                    out_pc    <= s1_pc;
                    out_op    <= s1_op;
                    out_rd    <= s1_rd;
                    out_imm   <= s1_imm;
                    out_ra    <= s1_ra;
                    out_rb    <= s1_rb;
                    out_a     <= s1_a;
                    out_b     <= s1_b;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end else if (out_valid) begin
                    out_a <= snoop_a;
                    out_b <= snoop_b;
                end

                if (in_valid && in_ready) begin
                    s1_valid <= 1'b1;
                    s1_pc    <= in_pc;
                    s1_op    <= in_op;
                    s1_ra    <= in_ra;
                    s1_rb    <= in_rb;
                    s1_rd    <= in_rd;
                    s1_imm   <= in_imm;
                end else if (s1_move) begin
                    s1_valid <= 1'b0;
                end
            end
        end
    end

endmodule
